// File: rtl/iter_shifter.sv
// Multi-cycle shifter/rotator: shifts by up to STEP bits per cycle until the requested
// amount is consumed. Supports SLL/SRL/ROL/SRA, valid/ready on both sides and a flush input.
module iter_shifter #(
    parameter  int WIDTH = 32,
    parameter  int STEP  = 4,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    localparam int              SHW1    = SHW + 1;
    localparam logic [SHW:0]    STEP_K  = SHW1'(STEP);
    localparam logic [SHW:0]    WIDTH_K = SHW1'(WIDTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] data, shifted;
    logic [1:0]       op;
    logic [SHW-1:0]   remaining, rem_next;
    logic [SHW:0]     k;
    logic             accept;

    assign in_ready  = !flush && (state == IDLE || (state == DONE && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    // k never exceeds remaining (< WIDTH), so truncating it to SHW bits is lossless.
    always_comb begin
        k        = ({1'b0, remaining} >= STEP_K) ? STEP_K : {1'b0, remaining};
        rem_next = remaining - k[SHW-1:0];
        shifted  = data;
        case (op)
            2'b00: shifted = data << k;
            2'b01: shifted = data >> k;
            2'b10: shifted = (data << k) | (data >> (WIDTH_K - k));
            2'b11: shifted = $unsigned($signed(data) >>> k);
        endcase
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: if (accept) state_next = (in_shamt == '0) ? DONE : BUSY;
                BUSY: if (rem_next == '0) state_next = DONE;
                DONE: if (out_ready) begin
                    if (accept) state_next = (in_shamt == '0) ? DONE : BUSY;
                    else        state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // out_data is a separate register so intermediate BUSY values never reach the port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data      <= '0;
            op        <= '0;
            remaining <= '0;
            out_data  <= '0;
        end else if (flush) begin
            remaining <= '0;
        end else if (accept) begin
            data      <= in_data;
            op        <= in_op;
            remaining <= in_shamt;
            if (in_shamt == '0) out_data <= in_data;
        end else if (state == BUSY) begin
            data      <= shifted;
            remaining <= rem_next;
            if (rem_next == '0) out_data <= shifted;
        end
    end

endmodule

// File: tb/tb_iter_shifter.sv
// Scoreboard bench for iter_shifter (WIDTH=32, STEP=4): directed scenarios plus random traffic.
module tb_iter_shifter;
    localparam int W  = 32;
    localparam int ST = 4;
    localparam int SW = 5;
    localparam int N_RAND = 10000;
    localparam int CAP    = 95000;

    logic          clk = 1'b0;
    logic          rst_n, flush, in_valid, in_ready, out_valid, out_ready, busy;
    logic [W-1:0]  in_data, out_data;
    logic [SW-1:0] in_shamt;
    logic [1:0]    in_op;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [W-1:0] exp;
        int           lat;
        int           acc_cyc;
    } item_t;
    item_t sb[$];

    always #5 clk = ~clk;

    iter_shifter #(.WIDTH(W), .STEP(ST)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_shamt(in_shamt), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy)
    );

    function automatic logic [W-1:0] model(input logic [W-1:0] d, input int s, input logic [1:0] op);
        case (op)
            2'b00:   return d << s;
            2'b01:   return d >> s;
            2'b10:   return (s == 0) ? d : ((d << s) | (d >> (W - s)));
            default: return $unsigned($signed(d) >>> s);
        endcase
    endfunction

    function automatic int lat_of(input int s);
        return (s + ST - 1) / ST;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [W-1:0] d, input int s, input logic [1:0] op);
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = SW'(s);
        in_op    = op;
        sb.push_back('{model(d, s, op), lat_of(s), 0});
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 20) begin
            step();
            cycles++;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        total++; if (out_data !== '0) begin bad++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_sll();
        int    c;
        item_t it;
        out_ready = 1'b0;
        drive_req(32'h0000_0001, 2, 2'b00);
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL sll_in_ready: got %b expected 1", in_ready); end
        step();
        in_valid = 1'b0;
        wait_valid(c);
        it = sb.pop_front();
        total++; if (c !== it.lat) begin bad++; $display("FAIL sll_latency: got %0d expected %0d", c, it.lat); end
        total++; if (out_data !== it.exp) begin bad++; $display("FAIL sll_data: got %h expected %h", out_data, it.exp); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0 || busy !== 1'b0)
            begin bad++; $display("FAIL sll_handoff: got valid=%b busy=%b expected 0 0", out_valid, busy); end
    endtask

    task automatic test_modes();
        logic [W-1:0] dv[7] = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0001, 32'hDEAD_BEEF,
                                32'h1234_5678, 32'h8765_4321, 32'h7FFF_FFFF};
        int           sv[7] = '{31, 31, 4, 0, 31, 13, 9};
        logic [1:0]   ov[7] = '{2'b11, 2'b01, 2'b10, 2'b00, 2'b10, 2'b11, 2'b11};
        int    c;
        item_t it;
        for (int i = 0; i < 7; i++) begin
            out_ready = 1'b0;
            drive_req(dv[i], sv[i], ov[i]);
            step();
            in_valid = 1'b0;
            wait_valid(c);
            it = sb.pop_front();
            total++; if (c !== it.lat) begin bad++; $display("FAIL mode%0d_latency: got %0d expected %0d", i, c, it.lat); end
            total++; if (out_data !== it.exp) begin bad++; $display("FAIL mode%0d_data: got %h expected %h", i, out_data, it.exp); end
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end
    endtask

    task automatic test_backpressure();
        int           c;
        item_t        it;
        logic [W-1:0] held;
        out_ready = 1'b0;
        drive_req(32'h0000_0001, 2, 2'b00);
        step();
        in_valid = 1'b0;
        wait_valid(c);
        held = out_data;
        for (int i = 0; i < 5; i++) begin
            step();
            total++; if (out_valid !== 1'b1 || out_data !== held)
                begin bad++; $display("FAIL bp_hold%0d: got valid=%b data=%h expected 1 %h", i, out_valid, out_data, held); end
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready%0d: got %b expected 0", i, in_ready); end
        end
        it = sb.pop_front();
        total++; if (out_data !== it.exp) begin bad++; $display("FAIL bp_first_data: got %h expected %h", out_data, it.exp); end
        drive_req(32'h0000_00F0, 4, 2'b01);
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_handoff_ready: got %b expected 1", in_ready); end
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0 || busy !== 1'b1)
            begin bad++; $display("FAIL bp_second_busy: got valid=%b busy=%b expected 0 1", out_valid, busy); end
        step();
        it = sb.pop_front();
        total++; if (out_valid !== 1'b1 || out_data !== it.exp)
            begin bad++; $display("FAIL bp_second_data: got valid=%b data=%h expected 1 %h", out_valid, out_data, it.exp); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_abort();
        logic [W-1:0] prev;
        logic         seen = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 32'h9000_0000; in_shamt = 5'd20; in_op = 2'b11;
        step();
        in_valid = 1'b0;
        step();
        step();
        prev  = out_data;
        flush = 1'b1;
        step();
        flush = 1'b0;
        total++; if (busy !== 1'b0 || out_valid !== 1'b0)
            begin bad++; $display("FAIL flush_idle: got busy=%b valid=%b expected 0 0", busy, out_valid); end
        total++; if (out_data !== prev) begin bad++; $display("FAIL flush_out_data: got %h expected %h", out_data, prev); end
        for (int i = 0; i < 8; i++) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL flush_no_result: got %b expected 0", seen); end

        flush = 1'b1;
        in_valid = 1'b1; in_data = 32'h0000_0005; in_shamt = '0; in_op = 2'b00;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready: got %b expected 0", in_ready); end
        step();
        flush = 1'b0; in_valid = 1'b0;
        total++; if (busy !== 1'b0 || out_valid !== 1'b0)
            begin bad++; $display("FAIL flush_blocks_accept: got busy=%b valid=%b expected 0 0", busy, out_valid); end

        in_valid = 1'b1; in_data = 32'h0000_ABCD; in_shamt = 5'd31; in_op = 2'b00;
        step();
        in_valid = 1'b0;
        step();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL pre_reset_busy: got %b expected 1", busy); end
        rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== '0 || in_ready !== 1'b1)
            begin bad++; $display("FAIL async_reset: got valid=%b busy=%b data=%h ready=%b expected 0 0 0 1",
                                  out_valid, busy, out_data, in_ready); end
        rst_n = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        int           cyc = 0, done_ops = 0, sent = 0, got;
        logic         seen = 1'b0, have_req = 1'b0;
        logic [W-1:0] rd;
        int           rs;
        logic [1:0]   ro;
        item_t        it;
        sb.delete();
        while (done_ops < N_RAND && cyc < CAP) begin
            if (!have_req && sent < N_RAND) begin
                rd = $urandom; rs = $urandom_range(0, W - 1); ro = 2'($urandom_range(0, 3));
                have_req = 1'b1;
            end
            in_data   = rd;
            in_shamt  = SW'(rs);
            in_op     = ro;
            in_valid  = have_req && ($urandom_range(0, 7) != 0);
            out_ready = ($urandom_range(0, 7) != 0);
            #1;
            if (out_valid && !seen) begin
                total++;
                if (sb.size() == 0) begin
                    bad++; $display("FAIL rand_spurious_valid: got 1 expected 0 at cycle %0d", cyc);
                end else begin
                    got = cyc - sb[0].acc_cyc - 1;
                    if (got != sb[0].lat) begin bad++; $display("FAIL rand_latency: got %0d expected %0d", got, sb[0].lat); end
                end
                seen = 1'b1;
            end
            if (out_valid && out_ready && sb.size() > 0) begin
                it = sb.pop_front();
                total++; if (out_data !== it.exp) begin bad++; $display("FAIL rand_data: got %h expected %h", out_data, it.exp); end
                seen = 1'b0;
                done_ops++;
            end
            if (in_valid && in_ready) begin
                sb.push_back('{model(rd, rs, ro), lat_of(rs), cyc});
                have_req = 1'b0;
                sent++;
            end
            step();
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        total++; if (done_ops != N_RAND) begin bad++; $display("FAIL rand_completed: got %0d expected %0d", done_ops, N_RAND); end
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_shamt = '0; in_op = '0;
        test_reset();
        test_sll();
        test_modes();
        test_backpressure();
        test_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
